// File: rtl/if_stage_ctrl.sv
// Fetch-stage sequencing controller: PC / IF/ID enables, flush and bubble controls,
// plus saturating stall and redirect counters.
module if_stage_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pc_src,
  input  logic             imem_ready,
  input  logic             id_ex_mem_read,
  input  logic [REG_W-1:0] id_ex_rt,
  input  logic [REG_W-1:0] if_id_rs,
  input  logic [REG_W-1:0] if_id_rt,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             ctrl_bubble,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    WAIT    = 2'd2,
    DISCARD = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] stall_cnt_reg, flush_cnt_reg;
  logic             stall_inc, flush_inc;
  logic             load_use;

  assign load_use = id_ex_mem_read && (id_ex_rt != '0) &&
                    ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= BOOT;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (stall_inc && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
      if (flush_inc && (flush_cnt_reg != '1))
        flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
    end
  end

  always_comb begin
    state_next   = state_reg;
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    ctrl_bubble  = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;

    case (state_reg)
      BOOT: begin
        if_id_flush = 1'b1;
        ctrl_bubble = 1'b1;
        state_next  = RUN;
      end
      RUN, WAIT: begin
        if (pc_src) begin
          // Redirect beats every stall; a pending fetch of the old address must be dropped.
          pc_write     = 1'b1;
          if_id_flush  = 1'b1;
          id_ex_flush  = 1'b1;
          ex_mem_flush = 1'b1;
          ctrl_bubble  = 1'b1;
          flush_inc    = 1'b1;
          state_next   = imem_ready ? RUN : DISCARD;
        end else if (!imem_ready) begin
          ctrl_bubble = 1'b1;
          stall_inc   = 1'b1;
          state_next  = WAIT;
        end else if (load_use) begin
          ctrl_bubble = 1'b1;
          stall_inc   = 1'b1;
          state_next  = RUN;
        end else begin
          pc_write    = 1'b1;
          if_id_write = 1'b1;
          state_next  = RUN;
        end
      end
      DISCARD: begin
        // pc_src is ignored here: EX/MEM was already flushed by the redirect.
        if_id_flush = 1'b1;
        ctrl_bubble = 1'b1;
        stall_inc   = 1'b1;
        state_next  = imem_ready ? RUN : DISCARD;
      end
      default: state_next = BOOT;
    endcase

    if (!rst_n) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      ctrl_bubble  = 1'b1;
      stall_inc    = 1'b0;
      flush_inc    = 1'b0;
    end
  end

  assign state     = state_reg;
  assign stall_cnt = stall_cnt_reg;
  assign flush_cnt = flush_cnt_reg;

endmodule

// File: tb/tb_if_stage_ctrl.sv
// Scoreboard bench for if_stage_ctrl: a behavioural model pushes expected outputs per
// driven cycle, which are popped and compared against the DUT before the next edge.
module tb_if_stage_ctrl;
  localparam int REG_W   = 5;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             pc_src = 1'b0;
  logic             imem_ready = 1'b1;
  logic             id_ex_mem_read = 1'b0;
  logic [REG_W-1:0] id_ex_rt = '0;
  logic [REG_W-1:0] if_id_rs = '0;
  logic [REG_W-1:0] if_id_rt = '0;
  logic             pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_flush, ctrl_bubble;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  if_stage_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .imem_ready(imem_ready),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt), .if_id_rs(if_id_rs),
    .if_id_rt(if_id_rt), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
    .ctrl_bubble(ctrl_bubble), .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    pw, iw, iif, ief, emf, cb, st, sc, fc;
    bit    iw_care;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  // Reference model state: 0 BOOT, 1 RUN, 2 WAIT, 3 DISCARD
  int m_state = 0;
  int m_stall = 0;
  int m_flush = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic compare_out();
    exp_t e;
    e = q.pop_front();
    check_eq({e.tag, ".pc_write"},     int'(pc_write),     e.pw);
    if (e.iw_care) check_eq({e.tag, ".if_id_write"}, int'(if_id_write), e.iw);
    check_eq({e.tag, ".if_id_flush"},  int'(if_id_flush),  e.iif);
    check_eq({e.tag, ".id_ex_flush"},  int'(id_ex_flush),  e.ief);
    check_eq({e.tag, ".ex_mem_flush"}, int'(ex_mem_flush), e.emf);
    check_eq({e.tag, ".ctrl_bubble"},  int'(ctrl_bubble),  e.cb);
    check_eq({e.tag, ".state"},        int'(state),        e.st);
    check_eq({e.tag, ".stall_cnt"},    int'(stall_cnt),    e.sc);
    check_eq({e.tag, ".flush_cnt"},    int'(flush_cnt),    e.fc);
    $display("cyc %0d %s: st=%0d pw=%0b iw=%0b fl=%0b%0b%0b cb=%0b stall=%0d flush=%0d",
             cyc, e.tag, state, pc_write, if_id_write, if_id_flush, id_ex_flush,
             ex_mem_flush, ctrl_bubble, stall_cnt, flush_cnt);
  endtask

  // One clock of stimulus: drive after the falling edge, check 1 time unit later.
  task automatic step(input string tag, input bit ps, input bit rdy, input bit mr,
                      input int xrt, input int xrs, input int xrt2);
    exp_t e;
    bit   lu, s_inc, f_inc;
    int   nxt;
    @(negedge clk);
    cyc++;
    pc_src = ps; imem_ready = rdy; id_ex_mem_read = mr;
    id_ex_rt = REG_W'(xrt); if_id_rs = REG_W'(xrs); if_id_rt = REG_W'(xrt2);
    lu = mr && (xrt != 0) && (xrt == xrs || xrt == xrt2);
    e = '{tag: tag, pw: 0, iw: 0, iif: 0, ief: 0, emf: 0, cb: 0,
          st: m_state, sc: m_stall, fc: m_flush, iw_care: 1'b1};
    s_inc = 0; f_inc = 0; nxt = m_state;
    if (m_state == 0) begin
      e.iif = 1; e.cb = 1; nxt = 1;
    end else if (m_state == 3) begin
      e.iif = 1; e.cb = 1; s_inc = 1; nxt = rdy ? 1 : 3;
    end else if (ps) begin
      e.pw = 1; e.iif = 1; e.ief = 1; e.emf = 1; e.cb = 1; e.iw_care = 1'b0;
      f_inc = 1; nxt = rdy ? 1 : 3;
    end else if (!rdy) begin
      e.cb = 1; s_inc = 1; nxt = 2;
    end else if (lu) begin
      e.cb = 1; s_inc = 1; nxt = 1;
    end else begin
      e.pw = 1; e.iw = 1; nxt = 1;
    end
    q.push_back(e);
    #1;
    compare_out();
    m_state = nxt;
    if (s_inc && m_stall < CNT_MAX) m_stall++;
    if (f_inc && m_flush < CNT_MAX) m_flush++;
  endtask

  // Assert reset asynchronously between edges and check the held-reset outputs.
  task automatic do_reset(input string tag);
    exp_t e;
    @(negedge clk);
    #2 rst_n = 1'b0;
    m_state = 0; m_stall = 0; m_flush = 0;
    e = '{tag: tag, pw: 0, iw: 0, iif: 1, ief: 1, emf: 1, cb: 1,
          st: 0, sc: 0, fc: 0, iw_care: 1'b1};
    q.push_back(e);
    #1;
    compare_out();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 1, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset and plain run: BOOT one cycle, then full-speed fetch.
    do_reset("reset");
    idle("boot_run", 4);

    // Load-use on rs, then on rt; register 0 never hazards.
    step("lu_rs", 0, 1, 1, 8, 8, 0);
    idle("after_lu", 1);
    step("lu_r0", 0, 1, 1, 0, 0, 0);
    step("lu_rt", 0, 1, 1, 9, 3, 9);
    step("lu_noload", 0, 1, 0, 9, 9, 9);
    idle("run", 1);

    // Redirect with memory ready: stays in RUN.
    step("redir_rdy", 1, 1, 0, 0, 0, 0);
    idle("after_redir", 1);

    // Three not-ready cycles, then the ready cycle resumes.
    for (int i = 0; i < 3; i++) step("imem_wait", 0, 0, 0, 0, 0, 0);
    idle("resume", 2);

    // Redirect with memory busy -> DISCARD; pc_src ignored there.
    step("redir_busy", 1, 0, 0, 0, 0, 0);
    step("discard", 1, 0, 0, 0, 0, 0);
    step("discard", 0, 0, 0, 0, 0, 0);
    step("discard_drop", 0, 1, 0, 0, 0, 0);
    idle("target", 2);

    // Redirect and load-use together: redirect wins.
    step("redir_lu", 1, 1, 1, 4, 4, 0);
    idle("run", 1);

    // Reset in the middle of DISCARD.
    step("redir_busy2", 1, 0, 0, 0, 0, 0);
    step("discard2", 0, 0, 0, 0, 0, 0);
    do_reset("reset_mid_discard");
    idle("boot_run2", 2);

    // Saturation: more stall cycles than the counter can hold.
    for (int i = 0; i < CNT_MAX + 5; i++) step("sat_stall", 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < CNT_MAX + 3; i++) begin
      step("sat_redir", 1, 1, 0, 0, 0, 0);
    end
    idle("sat_hold", 2);

    // Random mix against the model.
    do_reset("reset_rand");
    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
           $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_stage_ctrl.md
Name: if_stage_ctrl

Overview:
Sequencing controller for the instruction-fetch stage and the IF/ID register. It drives PC write-enable, IF/ID write-enable and the pipeline flush/bubble controls. Inputs are the branch-taken signal (pc_src, resolved in MEM), the load-use hazard terms from ID/EX and IF/ID, and a ready flag from a multi-cycle instruction memory. It sits beside the fetch datapath (PC, IMEM, IF/ID) and replaces the ad-hoc PCSrc driving with a defined FSM.

Parameters:
REG_W, 5, register-specifier width
CNT_W, 16, width of the saturating performance counters

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
pc_src  input  1  branch taken, from EX/MEM; PC selects the ex_mem target
imem_ready  input  1  IMEM data for the current PC is valid this cycle
id_ex_mem_read  input  1  instruction in EX is a load
id_ex_rt  input  REG_W  load destination register
if_id_rs  input  REG_W  rs of the instruction in ID
if_id_rt  input  REG_W  rt of the instruction in ID
pc_write  output  1  PC register load enable
if_id_write  output  1  IF/ID register load enable
if_id_flush  output  1  IF/ID is loaded with NOP (overrides if_id_write)
id_ex_flush  output  1  ID/EX is loaded with NOP
ex_mem_flush  output  1  EX/MEM control bits are cleared
ctrl_bubble  output  1  ID control signals are forced to zero
state  output  2  FSM state: BOOT=0, RUN=1, WAIT=2, DISCARD=3
stall_cnt  output  CNT_W  count of stall cycles, saturating
flush_cnt  output  CNT_W  count of redirects, saturating

Behaviour:
- The only registers are the state and the two counters. All other outputs are combinational from state and inputs.
- While rst_n=0:
  - state=BOOT, stall_cnt=0, flush_cnt=0.
  - Outputs: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, ex_mem_flush=1, ctrl_bubble=1.
  - Deassertion takes effect on the next clk edge.
- BOOT (exactly one cycle after reset):
  - Outputs: pc_write=0, if_id_write=0, if_id_flush=1, ctrl_bubble=1; other flushes 0.
  - Next state: RUN.
- load_use = id_ex_mem_read & (id_ex_rt != 0) & (id_ex_rt == if_id_rs | id_ex_rt == if_id_rt).
- RUN and WAIT share the decision logic below; conditions are evaluated in priority order.
  1. pc_src=1:
     - Outputs: pc_write=1, if_id_flush=1, id_ex_flush=1, ex_mem_flush=1, ctrl_bubble=1.
     - flush_cnt += 1.
     - Next state: RUN if imem_ready=1, otherwise DISCARD (an old-address fetch is still outstanding).
  2. imem_ready=0:
     - Outputs: pc_write=0, if_id_write=0, ctrl_bubble=1.
     - stall_cnt += 1.
     - Next state: WAIT.
  3. load_use=1:
     - Outputs: pc_write=0, if_id_write=0, ctrl_bubble=1.
     - stall_cnt += 1.
     - Next state: RUN.
  4. Otherwise:
     - Outputs: pc_write=1, if_id_write=1, all flushes 0, ctrl_bubble=0.
     - Next state: RUN.
- DISCARD:
  - Outputs: pc_write=0, if_id_write=0, if_id_flush=1, ctrl_bubble=1; other flushes 0.
  - stall_cnt += 1 each cycle.
  - The word returned with imem_ready=1 is dropped; next state RUN. The fetch at the target then starts in RUN.
  - pc_src is ignored in DISCARD, because EX/MEM was flushed.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Reset asserted in any state returns to BOOT immediately (asynchronous) and clears both counters.
- Redirect latency: pc_src high at edge N loads the PC at edge N+1. The first target instruction enters IF/ID one cycle after imem_ready (no extra cycle when memory is ready).

Test Plan:
- Reset then release, imem_ready=1 constant -> BOOT for 1 cycle, then RUN. pc_write=if_id_write=1 every cycle; counters stay 0.
- Load-use hazard: id_ex_mem_read=1, id_ex_rt=8, if_id_rs=8 -> pc_write=0, if_id_write=0, ctrl_bubble=1 for 1 cycle; stall_cnt=1.
- id_ex_rt=0 with if_id_rs=0 and mem_read=1 -> no stall.
- pc_src pulse with imem_ready=1 -> pc_write=1, all three flushes=1 for 1 cycle; flush_cnt=1; state stays RUN.
- imem_ready low for 3 cycles -> state WAIT, pc_write=0 for 3 cycles, stall_cnt=3; pipeline resumes on the ready cycle.
- pc_src=1 while imem_ready=0 -> PC loads and state enters DISCARD. After 2 further not-ready cycles and a ready cycle, that word is flushed (if_id_flush=1) and state returns to RUN.
- pc_src=1 and load_use=1 in the same cycle -> redirect wins: pc_write=1, flushes=1, stall_cnt unchanged.
- rst_n asserted mid-DISCARD -> immediate BOOT outputs and counters cleared to 0.
- Force stall_cnt to 2^CNT_W-1 (CNT_W=4 build), then stall -> the count holds at 15.
